// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: FSM state, funct3 codes, decode helpers.
// Used by load_store_unit and lsu_lane_align.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_D  = 3'b011;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;
  localparam logic [2:0] LSU_F3_WU = 3'b110;

  function automatic logic lsu_f3_legal(
    input logic       write,
    input logic [2:0] f3,
    input logic       is64
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_F3_B,
      LSU_F3_H,
      LSU_F3_W:  ok = 1'b1;
      LSU_F3_D:  ok = is64;
      LSU_F3_BU,
      LSU_F3_HU: ok = !write;
      LSU_F3_WU: ok = !write && is64;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Offset bits that must be zero for a naturally aligned access
  function automatic logic [2:0] lsu_low_mask(
    input logic [1:0] sz
  );
    logic [2:0] m;
    m = 3'd0;
    case (sz)
      2'd0:    m = 3'd0;
      2'd1:    m = 3'd1;
      2'd2:    m = 3'd3;
      default: m = 3'd7;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: enable mask, store replication,
// load lane select and sign/zero extension. Purely combinational.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 f3,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          be,
  output logic [XLEN-1:0]            wdata_rep,
  output logic [XLEN-1:0]            rdata_ext
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   mask;
  logic [XLEN-1:0] lane;
  logic            sgn;

  assign lane = rdata >> {off, 3'b000};
  assign sgn  = !f3[2];
  assign be   = mask << off;

  // Size mask before shifting into the addressed lane
  always_comb begin
    mask = '0;
    case (f3[1:0])
      2'd0:    mask = NB'(8'h01);
      2'd1:    mask = NB'(8'h03);
      2'd2:    mask = NB'(8'h0F);
      default: mask = NB'(8'hFF);
    endcase
  end

  // Replicate the low store unit across every lane
  always_comb begin
    wdata_rep = '0;
    case (f3[1:0])
      2'd0:    wdata_rep = {NB{wdata[7:0]}};
      2'd1:    wdata_rep = {(NB/2){wdata[15:0]}};
      2'd2:    wdata_rep = {(XLEN/32){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Extract the addressed lane and extend to XLEN
  always_comb begin
    rdata_ext = '0;
    case (f3[1:0])
      2'd0: rdata_ext = sgn ? XLEN'($signed(lane[7:0]))
                            : XLEN'(lane[7:0]);
      2'd1: rdata_ext = sgn ? XLEN'($signed(lane[15:0]))
                            : XLEN'(lane[15:0]);
      2'd2: rdata_ext = sgn ? XLEN'($signed(lane[31:0]))
                            : XLEN'(lane[31:0]);
      default: rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP.
// Build option: LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OW   = $clog2(NB);
  localparam int CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int WLIM = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
  localparam logic IS64 = (XLEN == 64);

  lsu_state_t        state_q;
  lsu_state_t        state_d;
  logic              live_q;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;
  logic [CW-1:0]     wait_q;

  logic              accept;
  logic              req_bad;
  logic              timeout;
  logic [OW-1:0]     off_al;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wrep;
  logic [XLEN-1:0]   rext;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic [OW-1:0] req_lowm;
  assign req_lowm = OW'(lsu_low_mask(req_funct3[1:0]));
  assign req_bad  =
    !lsu_f3_legal(req_write, req_funct3, IS64) ||
    ((req_addr[OW-1:0] & req_lowm) != '0);
`else
  assign req_bad =
    !lsu_f3_legal(req_write, req_funct3, IS64);
`endif

  // Offset rounded down to the access size
  assign off_al = addr_q[OW-1:0] &
                  ~OW'(lsu_low_mask(f3_q[1:0]));

  assign timeout = (MAX_WAIT != 0) && !mem_ready &&
                   (wait_q == CW'(WLIM));

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .f3        (f3_q),
    .off       (off_al),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );

  // State register; live_q holds off req_ready until first edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = req_bad ? RESP : ACCESS;
      ACCESS:
        if (mem_ready || timeout)
          state_d = RESP;
      RESP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and latched request
  always_comb begin
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = live_q;
      end
      ACCESS: begin
        mem_valid = 1'b1;
        mem_we    = write_q;
        mem_addr  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
        mem_be    = be;
        mem_wdata = write_q ? wrep : '0;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  // Request latch, wait counter and response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wait_q  <= '0;
    end else if (accept) begin
      write_q <= req_write;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= req_bad;
      rdata_q <= '0;
      wait_q  <= '0;
    end else if (state_q == ACCESS) begin
      if (mem_ready) begin
        err_q   <= 1'b0;
        rdata_q <= write_q ? '0 : rext;
      end else if (timeout) begin
        err_q <= 1'b1;
      end else if (MAX_WAIT != 0) begin
        wait_q <= wait_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32, MAX_WAIT=4).
// Expected values come from a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .XLEN     (32),
    .ADDR_W   (32),
    .MAX_WAIT (MW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // ---- reference model (RV32 rules, byte arithmetic) ----
  function automatic bit m_legal(bit w, int f3);
    if (w) return f3 inside {0, 1, 2};
    return f3 inside {0, 1, 2, 4, 5};
  endfunction

  function automatic int m_bytes(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic int m_off(logic [31:0] a, int f3);
    int b;
    b = m_bytes(f3);
    return ((int'(a % 4)) / b) * b;
  endfunction

  function automatic bit m_misal(logic [31:0] a, int f3);
    return (a % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [31:0] a,
                                      int f3);
    int v;
    v = ((1 << m_bytes(f3)) - 1) << m_off(a, f3);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d,
                                          int f3);
    int b;
    longint u;
    longint r;
    b = m_bytes(f3);
    u = longint'(d) & ((longint'(1) << (8 * b)) - 1);
    r = 0;
    for (int k = 0; k < 4 / b; k++)
      r = r | (u << (8 * b * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_rdata(logic [31:0] d,
                                          logic [31:0] a,
                                          int f3);
    int b;
    longint v;
    b = m_bytes(f3);
    v = longint'(d) >> (8 * m_off(a, f3));
    v = v & ((longint'(1) << (8 * b)) - 1);
    if (f3 < 4 && v >= (longint'(1) << (8 * b - 1)))
      v = v - (longint'(1) << (8 * b));
    return v[31:0];
  endfunction

  // One request with a scripted memory; waits >= MW never answers
  task automatic do_txn(input string tag, input bit w,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] rd,
                        input int waits, input bit noise);
    bit trap;
    bit early;
    bit exp_err;
    int exp_acc;
    int exp_lat;
    logic [31:0] exp_rd;
    int acc;
    int lat;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = 1'b1;
`endif
    early = !m_legal(w, int'(f3)) ||
            (trap && m_misal(addr, int'(f3)));
    exp_acc = early ? 0 : ((waits < MW) ? waits + 1 : MW);
    exp_err = early || (waits >= MW);
    exp_lat = early ? 1 : exp_acc + 1;
    exp_rd = (exp_err || w) ? 32'h0
           : m_rdata(rd, addr, int'(f3));

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ready  = noise ? 1'($urandom) : 1'b0;
    chk({tag, ":req_ready"}, 64'(req_ready), 64'(1));
    @(posedge clk);
    acc = 0;
    lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_valid) begin
        acc++;
        chk({tag, ":we"}, 64'(mem_we), 64'(w));
        chk({tag, ":addr"}, 64'(mem_addr),
            64'(addr & 32'hFFFF_FFFC));
        chk({tag, ":be"}, 64'(mem_be),
            64'(m_be(addr, int'(f3))));
        if (w)
          chk({tag, ":wdata"}, 64'(mem_wdata),
              64'(m_wdata(wd, int'(f3))));
        mem_ready = (acc == waits + 1);
        mem_rdata = rd;
      end else begin
        mem_ready = noise ? 1'($urandom) : 1'b0;
        mem_rdata = $urandom;
      end
      if (rsp_valid) begin
        lat = c;
        chk({tag, ":err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, ":rdata"}, 64'(rsp_rdata), 64'(exp_rd));
      end
    end
    chk({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ":access_cycles"}, 64'(acc), 64'(exp_acc));
    @(negedge clk);
    mem_ready = 1'b0;
    chk({tag, ":rsp_pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  int ld_f3[5] = '{0, 1, 2, 4, 5};
  int st_f3[3] = '{0, 1, 2};

  initial begin
    bit          w;
    logic [2:0]  f3;
    int          wt;

    // reset state
    #2;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_ctl",
        64'({mem_valid, mem_we, mem_be, rsp_valid, rsp_err}),
        64'(0));
    chk("rst_data",
        64'(mem_addr | mem_wdata | rsp_rdata), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready_pre", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("rel_ready_post", 64'(req_ready), 64'(1));

    // directed steps
    do_txn("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    chk("sw_be_const", 64'(m_be(32'h100, 2)), 64'hF);
    do_txn("lb", 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 0, 0);
    do_txn("lbu", 0, 3'b100, 32'h103, 0, 32'h80FF_0000, 0, 0);
    do_txn("sh", 1, 3'b001, 32'h102, 32'h1234, 0, 3, 0);
    do_txn("lw_mis", 0, 3'b010, 32'h101, 0, 32'hCAFEF00D,
           0, 0);
    do_txn("lh_mis", 0, 3'b001, 32'h203, 0, 32'h8001_7F00,
           1, 0);
    do_txn("tmo", 0, 3'b010, 32'h200, 0, 32'h5555, 99, 0);
    do_txn("tmo_edge", 0, 3'b010, 32'h200, 0, 32'h1357,
           MW - 1, 0);
    do_txn("ill_ld", 0, 3'b111, 32'h10, 0, 32'h1, 0, 0);
    do_txn("ill_st", 1, 3'b100, 32'h10, 32'h1, 0, 0, 0);
    do_txn("ill_ld64", 0, 3'b011, 32'h10, 0, 32'h1, 0, 0);
    do_txn("ill_sd", 1, 3'b011, 32'h10, 32'h1, 0, 0, 0);
    do_txn("stray_rdy", 0, 3'b101, 32'h32, 0, 32'hBEEF_0000,
           2, 1);

    // reset in the middle of an access
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    mem_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_valid1", 64'(mem_valid), 64'(1));
    @(negedge clk);
    chk("mid_valid2", 64'(mem_valid), 64'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(mem_valid), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(req_ready), 64'(0));
    do_txn("post_rst", 0, 3'b001, 32'h302, 0, 32'hF00D_1234,
           1, 0);
    do_txn("post_rst_tmo", 1, 3'b000, 32'h7, 32'hAB, 0,
           99, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      if ($urandom_range(0, 4) == 0)
        f3 = 3'($urandom);
      else if (w)
        f3 = 3'(st_f3[$urandom_range(0, 2)]);
      else
        f3 = 3'(ld_f3[$urandom_range(0, 4)]);
      wt = $urandom_range(0, 5);
      do_txn("rnd", w, f3, $urandom, $urandom, $urandom,
             wt, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 16, giving the memory wait-cycle limit; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request from the control FSM is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-009 The block SHALL have port req_funct3, input, 3 bits: access size and sign, using RISC-V load/store funct3 encoding.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits: the byte address.
REQ-011 The block SHALL have port req_wdata, input, XLEN bits: the store data, right-aligned.
REQ-012 The block SHALL have port mem_valid, output, 1 bit: a memory transaction is pending.
REQ-013 The block SHALL have port mem_ready, input, 1 bit: the memory has completed the transaction in this cycle.
REQ-014 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-015 The block SHALL have port mem_addr, output, ADDR_W bits: the word-aligned address, with the low log2(XLEN/8) bits equal to 0.
REQ-016 The block SHALL have port mem_be, output, XLEN/8 bits: byte enables.
REQ-017 The block SHALL have port mem_wdata, output, XLEN bits: lane-replicated store data.
REQ-018 The block SHALL have port mem_rdata, input, XLEN bits: the raw memory word, sampled when mem_ready is high.
REQ-019 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle pulse marking completion.
REQ-020 The block SHALL have port rsp_rdata, output, XLEN bits: the extended load result.
REQ-021 The block SHALL have port rsp_err, output, 1 bit: the access failed (illegal funct3, misaligned address, or timeout); it is valid only while rsp_valid is high.

Function
REQ-022 The block SHALL have FSM states IDLE, ACCESS and RESP, with req_ready=1 only in IDLE.
REQ-023 On req_valid&&req_ready the block SHALL latch req_write, req_funct3, req_addr and req_wdata; the registered transaction SHALL enter ACCESS and assert mem_valid in the next cycle.
REQ-024 Legal funct3: loads LB=000, LH=001, LW=010, LBU=100, LHU=101, plus LD=011 and LWU=110 when XLEN=64; stores SB=000, SH=001, SW=010, plus SD=011 when XLEN=64; any other code SHALL go IDLE->RESP with rsp_err=1 and no memory transaction.
REQ-025 In ACCESS the block SHALL hold mem_valid, mem_we, mem_addr, mem_be and mem_wdata stable until the cycle in which mem_ready=1, then go to RESP with mem_valid=0 in RESP.
REQ-026 The block SHALL set mem_be to the size mask (1, 3, 0xF or 0xFF) shifted left by the byte offset req_addr[log2(XLEN/8)-1:0]; loads SHALL drive mem_be with the same mask.
REQ-027 On stores, mem_wdata SHALL carry the low byte, halfword or word of req_wdata replicated across all lanes.
REQ-028 On loads, the block SHALL capture mem_rdata on the mem_ready cycle, select the lane by byte offset, and sign-extend (LB, LH, LW on XLEN=64) or zero-extend (LBU, LHU, LWU) it into rsp_rdata.
REQ-029 In RESP the block SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_rdata SHALL be 0 for stores and for errors.
REQ-030 Minimum latency SHALL be 2 cycles from the accept edge to the rsp_valid cycle, when mem_ready=1 in the first ACCESS cycle; each wait cycle adds 1.
REQ-031 When MAX_WAIT>0, the block SHALL count ACCESS cycles with mem_ready=0; when the count reaches MAX_WAIT it SHALL drop mem_valid, go to RESP, and assert rsp_err=1.
REQ-032 A mem_ready arriving in the same cycle the count reaches MAX_WAIT SHALL win: the access completes with no error.
REQ-033 mem_ready received outside ACCESS SHALL be ignored.

Reset
REQ-034 While reset=0 the block SHALL force IDLE asynchronously, including mid-transaction, with the wait counter at 0.
REQ-035 During reset all outputs SHALL be 0 except req_ready, which SHALL be 0 during reset and 1 from the first clock edge after reset release.

Configuration
REQ-036 The block SHALL be controlled by macro LSU_MISALIGN_TRAP_EN.
REQ-037 With LSU_MISALIGN_TRAP_EN defined, a halfword at an odd offset, a word at offset not 0 mod 4, or a doubleword at offset not 0 SHALL go IDLE->RESP with rsp_err=1 and no memory transaction.
REQ-038 With LSU_MISALIGN_TRAP_EN undefined, the block SHALL clear the offset bits below the access size, perform the access aligned down, and never raise rsp_err for misalignment.

Structure
REQ-039 lsu_state_t and the LSU_F3_* funct3 constants SHALL live in the shared types package.
REQ-040 Lane mask, store-data replication and load extraction/extension SHALL be one combinational sub-module, lsu_lane_align.

Verification
REQ-041 A bench SHALL show: SW addr 0x100, data 0xDEADBEEF, mem_ready immediate -> mem_be=0xF, mem_wdata=0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-042 A bench SHALL show: LB addr 0x103, mem_rdata=0x80FF_0000 -> rsp_rdata=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-043 A bench SHALL show: SH addr 0x102, data 0x1234, 3 wait cycles -> mem_be=0xC, mem_wdata=0x1234_1234 held stable for 4 cycles, rsp_valid 5 cycles after accept.
REQ-044 A bench SHALL show: LW addr 0x101 with LSU_MISALIGN_TRAP_EN defined -> no mem_valid, rsp_err=1; with it undefined -> mem_addr=0x100, mem_be=0xF.
REQ-045 A bench SHALL show: MAX_WAIT=4 with mem_ready held 0 -> mem_valid drops after 4 ACCESS cycles and rsp_err=1; mem_ready=1 on the 4th cycle -> rsp_err=0.
REQ-046 A bench SHALL show: reset=0 asserted mid-ACCESS -> mem_valid=0 immediately, and the next request after release proceeds normally.
